reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Tracks outstanding register writes between decode/issue and writeback.
- Stalls issue of any instruction whose source registers still have a write in flight.
- Records each accepted write at issue and retires it when the writeback port reports it, so it covers arbitrary writeback latency.
- Drives PC enable, IF/ID enable and the ID/EX bubble mux select.

Parameters:
- CNT_W, 2, width of the per-register in-flight counter; max in-flight writes per register = 2^CNT_W - 1.
- BYPASS_WB, 1, when 1 a same-cycle writeback that retires a register's last pending write clears that register's hazard in the same cycle (register file writes before it is read).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- issue_valid  input  1  decode holds a valid instruction.
- issue_rs1  input  5  source register 1 of the decoding instruction.
- issue_rs2  input  5  source register 2 of the decoding instruction.
- issue_regwrite  input  1  decoding instruction writes issue_rd.
- issue_rd  input  5  destination register of the decoding instruction.
- wb_valid  input  1  writeback of one tracked write this cycle.
- wb_rd  input  5  register being written back.
- flush  input  1  discard all in-flight tracking (pipeline flush).
- stall  output  1  issue blocked this cycle.
- PC_En  output  1  ~stall.
- IF_ID_En  output  1  ~stall.
- Mux_sel  output  1  stall; selects a bubble into ID/EX.
- pending  output  32  bit r = (count[r] != 0); bit 0 is always 0.
- wb_underflow  output  1  sticky error flag.

Behaviour:
- State: count[1..31], each CNT_W bits; x0 has no counter. One wb_underflow flop.
- Reset: all counts = 0 and wb_underflow = 0. Resulting outputs: stall=0, PC_En=1, IF_ID_En=1, Mux_sel=0, pending=0.
- Reset asserted mid-operation clears state immediately (asynchronous). Writebacks of instructions issued before reset then land on zero counts and set wb_underflow.
- src_hit(r) = (r != 0) && (count[r] != 0) && !(BYPASS_WB && wb_valid && wb_rd == r && count[r] == 1).
- full = issue_regwrite && issue_rd != 0 && count[issue_rd] == max.
- stall = issue_valid && (src_hit(rs1) || src_hit(rs2) || full). The stall path is purely combinational from registered counts and the current inputs.
- accept = issue_valid && !stall && issue_regwrite && issue_rd != 0.
- retire = wb_valid && wb_rd != 0 && count[wb_rd] != 0.
- Per-register count update at the clock edge:
  - +1 when accept targets the register.
  - -1 when retire targets the register.
  - Unchanged when both target the same register in the same cycle.
- wb_valid with wb_rd == 0: ignored.
- wb_valid with wb_rd != 0 and count[wb_rd] == 0: no count change; wb_underflow set to 1 and held until reset.
- flush = 1: all counts cleared at the edge; accept and retire are ignored that cycle; wb_underflow unaffected. stall is still computed from pre-flush state during the flush cycle.
- WAW is not a hazard. Multiple writes to the same rd may be in flight up to max; the count saturates by stalling via full, never by wrapping.
- Latency: an issued write is visible to stall in the cycle after acceptance. A retire is visible in the next cycle, or the same cycle when BYPASS_WB=1 and it retires the last pending write.

Test Plan:
- RAW stall: issue rd=5 (accept), next cycle issue rs1=5 -> stall=1, PC_En=0, Mux_sel=1. Pulse wb_rd=5 with BYPASS_WB=1 -> stall=0 in that same cycle; pending[5]=0 after the edge.
- x0 handling: issue rd=0 then rs1=0, rs2=0 -> stall stays 0, pending stays 0. wb_rd=0 -> no underflow.
- Saturation, CNT_W=2: three accepted writes to rd=7 -> count 3. Fourth issue with rd=7 and unrelated sources -> stall=1 from full. One wb_rd=7 -> count 2, and the fourth issue is accepted next cycle.
- Simultaneous events: count[9]=1, same cycle accept rd=9 and wb_rd=9 -> count[9] stays 1 and pending[9]=1.
- Flush and underflow: pending rd=3 and rd=4, assert flush -> pending=0 next cycle. Later wb_rd=3 -> wb_underflow=1, held until rst.
- Async reset mid-operation: counts nonzero and stall=1, assert rst between clock edges -> stall=0 and pending=0 immediately, before the next edge.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts in-flight writes per architectural register and
// stalls issue while a source register still has a write outstanding.
module reg_scoreboard #(
  parameter int unsigned CNT_W     = 2,
  parameter bit          BYPASS_WB = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic        issue_regwrite,
  input  logic [4:0]  issue_rd,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        stall,
  output logic        PC_En,
  output logic        IF_ID_En,
  output logic        Mux_sel,
  output logic [31:0] pending,
  output logic        wb_underflow
);

  localparam int unsigned NREG = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Entry 0 is held at zero: x0 is never tracked.
  logic [CNT_W-1:0] count [NREG];

  logic [NREG-1:0] busy;
  logic [NREG-1:0] hit;
  logic            full;
  logic            stall_c;
  logic            accept;
  logic            retire;
  logic            underflow_evt;

  // Hazard detection from registered counts and current-cycle inputs.
  always_comb begin
    busy = '0;
    hit  = '0;
    for (int r = 1; r < NREG; r++) begin
      busy[r] = (count[r] != '0);
      hit[r]  = busy[r] &&
                !(BYPASS_WB && wb_valid && (wb_rd == 5'(r)) && (count[r] == CNT_ONE));
    end
    full          = issue_regwrite && (issue_rd != 5'd0) && (count[issue_rd] == CNT_MAX);
    stall_c       = issue_valid && (hit[issue_rs1] || hit[issue_rs2] || full);
    accept        = issue_valid && !stall_c && issue_regwrite && (issue_rd != 5'd0);
    retire        = wb_valid && (wb_rd != 5'd0) && (count[wb_rd] != '0);
    underflow_evt = wb_valid && (wb_rd != 5'd0) && (count[wb_rd] == '0);
  end

  // Per-register counters; a matching accept and retire cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) count[r] <= '0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) count[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if ((accept && (issue_rd == 5'(r))) && !(retire && (wb_rd == 5'(r))))
          count[r] <= count[r] + CNT_ONE;
        else if ((retire && (wb_rd == 5'(r))) && !(accept && (issue_rd == 5'(r))))
          count[r] <= count[r] - CNT_ONE;
      end
    end
  end

  // Sticky: only reset clears a writeback that found nothing to retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                wb_underflow <= 1'b0;
    else if (underflow_evt) wb_underflow <= 1'b1;
  end

  assign stall    = stall_c;
  assign PC_En    = ~stall_c;
  assign IF_ID_En = ~stall_c;
  assign Mux_sel  = stall_c;
  assign pending  = busy;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard (CNT_W=2, BYPASS_WB=1).
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_regwrite;
  logic [4:0]  issue_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        stall;
  logic        PC_En;
  logic        IF_ID_En;
  logic        Mux_sel;
  logic [31:0] pending;
  logic        wb_underflow;

  int passed = 0;
  int total  = 0;

  reg_scoreboard #(.CNT_W(2), .BYPASS_WB(1'b1)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_regwrite(issue_regwrite), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall(stall), .PC_En(PC_En), .IF_ID_En(IF_ID_En), .Mux_sel(Mux_sel),
    .pending(pending), .wb_underflow(wb_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0;
    issue_regwrite = 0; issue_rd = 0;
    wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic we, input logic [4:0] rd);
    issue_valid = 1; issue_rs1 = rs1; issue_rs2 = rs2;
    issue_regwrite = we; issue_rd = rd;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    #2;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else passed++;
    total++; if (PC_En !== 1'b1) $display("FAIL reset_pc_en got=%b exp=1", PC_En); else passed++;
    total++; if (IF_ID_En !== 1'b1) $display("FAIL reset_ifid_en got=%b exp=1", IF_ID_En); else passed++;
    total++; if (Mux_sel !== 1'b0) $display("FAIL reset_mux_sel got=%b exp=0", Mux_sel); else passed++;
    total++; if (pending !== 32'h0) $display("FAIL reset_pending got=%h exp=0", pending); else passed++;
    total++; if (wb_underflow !== 1'b0) $display("FAIL reset_underflow got=%b exp=0", wb_underflow); else passed++;
    step();
    rst = 0;
    step();
  endtask

  task automatic test_raw();
    issue(5'd1, 5'd2, 1'b1, 5'd5);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL raw_first_issue stall got=%b exp=0", stall); else passed++;
    step();
    total++; if (pending !== 32'h0000_0020) $display("FAIL raw_pending5 got=%h exp=00000020", pending); else passed++;
    issue(5'd5, 5'd0, 1'b0, 5'd0);
    #1;
    total++; if (stall !== 1'b1) $display("FAIL raw_stall got=%b exp=1", stall); else passed++;
    total++; if (PC_En !== 1'b0) $display("FAIL raw_pc_en got=%b exp=0", PC_En); else passed++;
    total++; if (IF_ID_En !== 1'b0) $display("FAIL raw_ifid_en got=%b exp=0", IF_ID_En); else passed++;
    total++; if (Mux_sel !== 1'b1) $display("FAIL raw_mux_sel got=%b exp=1", Mux_sel); else passed++;
    step();
    total++; if (stall !== 1'b1) $display("FAIL raw_stall_held got=%b exp=1", stall); else passed++;
    wb_valid = 1; wb_rd = 5'd5;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL raw_bypass stall got=%b exp=0", stall); else passed++;
    step();
    idle();
    #1;
    total++; if (pending !== 32'h0) $display("FAIL raw_retired pending got=%h exp=0", pending); else passed++;
  endtask

  task automatic test_x0();
    issue(5'd0, 5'd0, 1'b1, 5'd0);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL x0_write stall got=%b exp=0", stall); else passed++;
    step();
    issue(5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL x0_read stall got=%b exp=0", stall); else passed++;
    total++; if (pending !== 32'h0) $display("FAIL x0_pending got=%h exp=0", pending); else passed++;
    idle();
    wb_valid = 1; wb_rd = 5'd0;
    step();
    idle();
    total++; if (wb_underflow !== 1'b0) $display("FAIL x0_wb_underflow got=%b exp=0", wb_underflow); else passed++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      issue(5'd0, 5'd0, 1'b1, 5'd7);
      #1;
      total++; if (stall !== 1'b0) $display("FAIL sat_fill%0d stall got=%b exp=0", i, stall); else passed++;
      step();
    end
    issue(5'd1, 5'd2, 1'b1, 5'd7);
    #1;
    total++; if (stall !== 1'b1) $display("FAIL sat_full stall got=%b exp=1", stall); else passed++;
    step();
    wb_valid = 1; wb_rd = 5'd7;
    #1;
    total++; if (stall !== 1'b1) $display("FAIL sat_full_during_wb stall got=%b exp=1", stall); else passed++;
    step();
    wb_valid = 0; wb_rd = 0;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL sat_accept_after_wb stall got=%b exp=0", stall); else passed++;
    step();
    #1;
    total++; if (stall !== 1'b1) $display("FAIL sat_full_again stall got=%b exp=1", stall); else passed++;
    idle();
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1; wb_rd = 5'd7;
      step();
      if (i == 1) begin
        total++; if (pending[7] !== 1'b1) $display("FAIL sat_drain_partial pending7 got=%b exp=1", pending[7]); else passed++;
      end
    end
    idle();
    total++; if (pending !== 32'h0) $display("FAIL sat_drained pending got=%h exp=0", pending); else passed++;
    total++; if (wb_underflow !== 1'b0) $display("FAIL sat_no_underflow got=%b exp=0", wb_underflow); else passed++;
  endtask

  task automatic test_simultaneous();
    issue(5'd0, 5'd0, 1'b1, 5'd9);
    step();
    wb_valid = 1; wb_rd = 5'd9;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL sim_issue stall got=%b exp=0", stall); else passed++;
    step();
    idle();
    total++; if (pending !== 32'h0000_0200) $display("FAIL sim_pending9 got=%h exp=00000200", pending); else passed++;
    wb_valid = 1; wb_rd = 5'd9;
    step();
    idle();
    total++; if (pending !== 32'h0) $display("FAIL sim_count_was_one pending got=%h exp=0", pending); else passed++;
    total++; if (wb_underflow !== 1'b0) $display("FAIL sim_no_underflow got=%b exp=0", wb_underflow); else passed++;
  endtask

  task automatic test_flush_underflow();
    issue(5'd0, 5'd0, 1'b1, 5'd3);
    step();
    issue(5'd0, 5'd0, 1'b1, 5'd4);
    step();
    idle();
    total++; if (pending !== 32'h0000_0018) $display("FAIL flush_pre pending got=%h exp=00000018", pending); else passed++;
    issue(5'd3, 5'd0, 1'b1, 5'd10);
    flush = 1;
    #1;
    total++; if (stall !== 1'b1) $display("FAIL flush_cycle stall got=%b exp=1", stall); else passed++;
    step();
    idle();
    total++; if (pending !== 32'h0) $display("FAIL flush_post pending got=%h exp=0", pending); else passed++;
    total++; if (wb_underflow !== 1'b0) $display("FAIL flush_underflow_clear got=%b exp=0", wb_underflow); else passed++;
    wb_valid = 1; wb_rd = 5'd3;
    step();
    idle();
    total++; if (wb_underflow !== 1'b1) $display("FAIL underflow_set got=%b exp=1", wb_underflow); else passed++;
    step(); step();
    total++; if (wb_underflow !== 1'b1) $display("FAIL underflow_sticky got=%b exp=1", wb_underflow); else passed++;
  endtask

  task automatic test_async_reset();
    issue(5'd0, 5'd0, 1'b1, 5'd6);
    step();
    issue(5'd6, 5'd0, 1'b0, 5'd0);
    #1;
    total++; if (stall !== 1'b1) $display("FAIL areset_pre stall got=%b exp=1", stall); else passed++;
    #1;
    rst = 1;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL areset_stall got=%b exp=0", stall); else passed++;
    total++; if (pending !== 32'h0) $display("FAIL areset_pending got=%h exp=0", pending); else passed++;
    total++; if (wb_underflow !== 1'b0) $display("FAIL areset_underflow got=%b exp=0", wb_underflow); else passed++;
    step();
    rst = 0;
    idle();
    wb_valid = 1; wb_rd = 5'd6;
    step();
    idle();
    total++; if (wb_underflow !== 1'b1) $display("FAIL areset_stale_wb got=%b exp=1", wb_underflow); else passed++;
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_raw();
    test_x0();
    test_saturation();
    test_simultaneous();
    test_flush_underflow();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
